demux_1to4: RTL and testbench

Registered 1-to-4 demultiplexer: routes a DATA_W-bit input to one of four output lanes selected by a 2-bit select, driving all unselected lanes to zero. Used as a leaf routing element wherever a single source fans out to one of four consumers under control of a select field. Outputs are registered on the single system clock, giving one cycle of latency and glitch-free lanes.

---
 rtl/demux_pkg.sv | 7 +
 rtl/demux_1to4_dec.sv | 9 +
 rtl/demux_1to4.sv | 41 ++++
 tb/tb_demux_1to4.sv | 86 ++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared lane-count, select and lane-mask types for the 1-to-4 demux
package demux_pkg;
  localparam int N_LANES = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/demux_1to4_dec.sv
// demux_1to4_dec: combinational decode of a lane select into a one-hot lane mask
module demux_1to4_dec
  import demux_pkg::*;
(
  input  sel_t       sel,
  output lane_mask_t mask
);
  assign mask = lane_mask_t'(1) << sel;
endmodule

// File: rtl/demux_1to4.sv
// demux_1to4: registered 1-to-4 demux with zeroed idle lanes; DEMUX_1TO4_HOLD_EN makes en=0 hold instead of clear
module demux_1to4
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [DATA_W-1:0]         din,
  input  sel_t                      sel,
  output logic [N_LANES*DATA_W-1:0] dout,
  output lane_mask_t                lane_vld
);
  lane_mask_t mask;
  logic [N_LANES*DATA_W-1:0] lanes;
  demux_1to4_dec u_dec (
    .sel  (sel),
    .mask (mask)
  );
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign lanes[k*DATA_W +: DATA_W] = mask[k] ? din : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout     <= '0;
      lane_vld <= '0;
    end
`ifdef DEMUX_1TO4_HOLD_EN
    else if (en) begin
      dout     <= lanes;
      lane_vld <= mask;
    end
`else
    else begin
      dout     <= en ? lanes : '0;
      lane_vld <= en ? mask : '0;
    end
`endif
  end
endmodule

// File: tb/tb_demux_1to4.sv
// tb_demux_1to4: directed scoreboard bench for 1-bit and 8-bit demux_1to4 instances
module tb_demux_1to4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic din1 = 1'b0;
  logic [7:0] din8 = 8'h00;
  logic [3:0] dout1, vld1, vld8;
  logic [31:0] dout8;
  typedef struct packed {
    logic [3:0]  d1;
    logic [3:0]  v;
    logic [31:0] d8;
  } exp_t;
  exp_t q[$];
  exp_t cur = '0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  demux_1to4 #(.DATA_W(1)) u_d1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din1),
    .sel      (sel),
    .dout     (dout1),
    .lane_vld (vld1)
  );
  demux_1to4 #(.DATA_W(8)) u_d8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din8),
    .sel      (sel),
    .dout     (dout8),
    .lane_vld (vld8)
  );
  task automatic step(input logic r, input logic e, input logic [1:0] s, input logic d, input logic [7:0] d8);
    exp_t x;
    rst_n = r;
    en = e;
    sel = s;
    din1 = d;
    din8 = d8;
    if (!r) cur = '0;
    else if (e) begin
      cur.d1 = 4'(d) << s;
      cur.v  = 4'b0001 << s;
      cur.d8 = 32'(d8) << (8 * s);
    end
`ifndef DEMUX_1TO4_HOLD_EN
    else cur = '0;
`endif
    q.push_back(cur);
    @(posedge clk);
    #1;
    x = q.pop_front();
    n_chk++;
    assert (dout1 === x.d1) else begin n_fail++; $error("FAIL dout1 got %b expected %b", dout1, x.d1); end
    n_chk++;
    assert (vld1 === x.v) else begin n_fail++; $error("FAIL lane_vld1 got %b expected %b", vld1, x.v); end
    n_chk++;
    assert (dout8 === x.d8) else begin n_fail++; $error("FAIL dout8 got %h expected %h", dout8, x.d8); end
    n_chk++;
    assert (vld8 === x.v) else begin n_fail++; $error("FAIL lane_vld8 got %b expected %b", vld8, x.v); end
  endtask
  initial begin
    step(1'b0, 1'b1, 2'd2, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 2'd2, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 2'd2, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 2'd0, 1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'(i), 1'b1, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'(i), 1'b0, 8'h00);
    step(1'b1, 1'b1, 2'd3, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 2'd1, 1'b1, 8'hFF);
    step(1'b1, 1'b0, 2'd0, 1'b0, 8'h5A);
    step(1'b1, 1'b1, 2'd1, 1'b1, 8'h81);
    step(1'b0, 1'b1, 2'd1, 1'b1, 8'h81);
    step(1'b1, 1'b1, 2'd1, 1'b1, 8'h81);
    step(1'b1, 1'b1, 2'd3, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 2'd2, 1'b0, 8'h01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
